booth_pp_sequencer: RTL and testbench
=====================================

Name: booth_pp_sequencer

Overview:
- Sequential radix-4 Modified Booth partial-product generator.
- Sits between the operand source and the Wallace-tree reduction stage of the 8-bit MBA multiplier.
- Accepts a signed multiplicand/multiplier pair and recodes the multiplier one overlapping triplet per step.
- Emits one shifted, sign-extended partial product per handshake; also accumulates them so the final product is available for self-check.

Parameters:
- WIDTH, 8, operand width in bits; must be even and at least 4.
- NPP, WIDTH/2, number of partial products (derived; not overridable).

Ports:
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  operand pair valid.
- in_ready  output  1  block can accept an operand pair.
- in_a  input  WIDTH  multiplicand, two's complement.
- in_b  input  WIDTH  multiplier, two's complement.
- pp_valid  output  1  partial product valid.
- pp_ready  input  1  downstream accepts partial product.
- pp_data  output  2*WIDTH  partial product, already shifted by 2*pp_index, sign-extended, modulo 2^(2*WIDTH).
- pp_digit  output  3  Booth digit as {neg,two,one}: 0=000, +1=001, +2=010, -1=101, -2=110.
- pp_index  output  clog2(NPP)  partial product number, 0..NPP-1.
- pp_last  output  1  high with pp_valid when pp_index = NPP-1.
- prod  output  2*WIDTH  accumulated product of the last completed operation.
- prod_valid  output  1  one-cycle pulse when prod updates.

Behaviour:
- Reset (async, any state): state=IDLE; in_ready=1; pp_valid=0, pp_data=0, pp_digit=000, pp_index=0, pp_last=0; prod=0, prod_valid=0; accumulator=0.
- State IDLE:
  - in_ready=1, pp_valid=0.
  - in_valid=1 at an edge: latch A=in_a and B={in_b,1'b0} (implicit B[-1]=0); clear accumulator and index; go to GEN.
- State GEN:
  - in_ready=0; pp_valid=1; outputs reflect index i.
  - Triplet t={B[2i+1],B[2i],B[2i-1]}. Digit map: 000/111→0; 001/010→+1; 011→+2; 100→-2; 101/110→-1.
  - pp_data=(digit × sign-extended A) << 2i, truncated to 2*WIDTH bits.
  - pp_data, pp_digit, pp_index, pp_last are registered and stable while pp_valid=1 and pp_ready=0.
  - Transfer occurs when pp_valid and pp_ready are both high at an edge: accumulator += pp_data (mod 2^(2*WIDTH)); i increments.
  - Transfer with i=NPP-1: go to DONE.
- State DONE (one cycle):
  - prod=accumulator, prod_valid=1, pp_valid=0, in_ready=0.
  - Next cycle: return to IDLE.
  - prod holds its value until the next DONE or reset.
- Latency with pp_ready held at 1:
  - Accept at edge 0.
  - pp_index 0 valid in cycle 1; last partial product in cycle NPP.
  - prod_valid in cycle NPP+1; in_ready=1 again in cycle NPP+2.
  - Each cycle with pp_ready=0 adds exactly one cycle.
- Boundary rules:
  - in_valid is ignored outside IDLE; no operand is queued.
  - pp_ready is ignored when pp_valid=0.
  - Most-negative operands (-2^(WIDTH-1) × -2^(WIDTH-1)) must give the exact positive result; no overflow in 2*WIDTH bits.
  - Zero digits still produce a handshake with pp_data=0.
  - Reset mid-GEN or mid-DONE aborts the operation; no prod_valid pulse; prod returns to 0.

Test Plan:
- Basic: a=3, b=5, pp_ready=1.
  - Required pp sequence: (0x0003, 001), (0x000C, 001), (0x0000, 000), (0x0000, 000).
  - pp_last only on index 3; prod=0x000F with prod_valid in cycle 5.
- Extreme: a=-128, b=-128.
  - Required: pp0..pp2=0x0000 with digit 000; pp3=0x4000 with digit 110 (-2); prod=0x4000.
- Negative digit: a=127, b=-1.
  - Required: pp0=0xFF81 with digit 101 (-1); pp1..pp3=0; prod=0xFF81.
- Backpressure: a=3, b=5, with pp_ready low for 3 cycles during index 1.
  - Required: pp_data=0x000C, pp_index=1 held stable throughout.
  - Prod still 0x000F; prod_valid delayed by exactly 3 cycles.
- Reset abort: assert rst during GEN at index 2.
  - Required: all outputs immediately at reset values; no prod_valid.
  - A new pair (a=-7, b=6) then yields prod=0xFFD6.
- Random: 1000 random signed pairs with random pp_ready.
  - Required: prod equals a×b (16-bit) every time.
  - Sum of emitted pp_data equals prod.
  - in_valid pulses outside IDLE are never accepted.

Source files
------------

// File: rtl/booth_pp_sequencer.sv
// booth_pp_sequencer
// Sequential radix-4 Modified Booth partial-product generator. One operand
// pair is accepted in IDLE. The multiplier is then recoded one overlapping
// triplet per step, and one shifted, sign-extended partial product is emitted
// per pp handshake. The partial products are also summed internally, and the
// resulting product is published for one cycle in DONE.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   in_valid/in_ready  operand handshake (in_a multiplicand, in_b multiplier)
//   pp_valid/pp_ready  partial-product handshake
//   pp_data            partial product, shifted by 2*pp_index, modulo 2^(2*WIDTH)
//   pp_digit           Booth digit {neg,two,one}
//   pp_index, pp_last  partial-product number and last flag
//   prod, prod_valid   accumulated product and its one-cycle update pulse
module booth_pp_sequencer #(
  parameter int WIDTH = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           in_valid,
  output logic                           in_ready,
  input  logic [WIDTH-1:0]               in_a,
  input  logic [WIDTH-1:0]               in_b,
  output logic                           pp_valid,
  input  logic                           pp_ready,
  output logic [2*WIDTH-1:0]             pp_data,
  output logic [2:0]                     pp_digit,
  output logic [$clog2(WIDTH/2)-1:0]     pp_index,
  output logic                           pp_last,
  output logic [2*WIDTH-1:0]             prod,
  output logic                           prod_valid
);

  localparam int NPP = WIDTH / 2;
  localparam int IW  = $clog2(NPP);
  localparam int PW  = 2 * WIDTH;

  typedef enum logic [1:0] {IDLE, GEN, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] a_reg;
  logic [WIDTH:0]   b_reg;    // multiplier with the implicit B[-1]=0 appended at bit 0
  logic [PW-1:0]    acc_reg;

  // The next partial product is computed ahead of time so that the pp outputs
  // can be registered. In IDLE the source is the incoming pair at index 0.
  // In GEN it is the latched pair at the following index.
  logic [WIDTH-1:0] src_a;
  logic [WIDTH:0]   src_b;
  logic [IW-1:0]    nxt_idx;
  logic [2:0]       trip;
  logic [2:0]       nxt_digit;
  logic [PW-1:0]    a_ext;
  logic [PW-1:0]    mag;
  logic [PW-1:0]    nxt_data;
  logic             nxt_last;

  always_comb begin
    src_a   = a_reg;
    src_b   = b_reg;
    nxt_idx = pp_index + 1'b1;
    if (state == IDLE) begin
      src_a   = in_a;
      src_b   = {in_b, 1'b0};
      nxt_idx = '0;
    end

    // Triplet {B[2i+1],B[2i],B[2i-1]} sits at bits [2i+2:2i] of src_b.
    trip = 3'(src_b >> {nxt_idx, 1'b0});

    case (trip)
      3'b001, 3'b010: nxt_digit = 3'b001;  // +1
      3'b011:         nxt_digit = 3'b010;  // +2
      3'b100:         nxt_digit = 3'b110;  // -2
      3'b101, 3'b110: nxt_digit = 3'b101;  // -1
      default:        nxt_digit = 3'b000;  // 0
    endcase

    // The magnitude is computed in the full 2*WIDTH width. This way 2*(-2^(W-1))
    // cannot overflow before negation.
    a_ext = {{WIDTH{src_a[WIDTH-1]}}, src_a};
    if (nxt_digit[1])
      mag = a_ext << 1;
    else if (nxt_digit[0])
      mag = a_ext;
    else
      mag = '0;

    nxt_data = (nxt_digit[2] ? (~mag + 1'b1) : mag) << {nxt_idx, 1'b0};
    nxt_last = (nxt_idx == IW'(NPP - 1));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      in_ready   <= 1'b1;
      pp_valid   <= 1'b0;
      pp_data    <= '0;
      pp_digit   <= 3'b000;
      pp_index   <= '0;
      pp_last    <= 1'b0;
      prod       <= '0;
      prod_valid <= 1'b0;
      acc_reg    <= '0;
      a_reg      <= '0;
      b_reg      <= '0;
    end else begin
      prod_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg    <= in_a;
            b_reg    <= {in_b, 1'b0};
            acc_reg  <= '0;
            in_ready <= 1'b0;
            pp_valid <= 1'b1;
            pp_data  <= nxt_data;
            pp_digit <= nxt_digit;
            pp_index <= nxt_idx;
            pp_last  <= nxt_last;
            state    <= GEN;
          end
        end
        GEN: begin
          if (pp_ready) begin
            acc_reg <= acc_reg + pp_data;
            if (pp_last) begin
              // The accumulator is bypassed so that prod includes the final partial product.
              pp_valid   <= 1'b0;
              prod       <= acc_reg + pp_data;
              prod_valid <= 1'b1;
              state      <= DONE;
            end else begin
              pp_data  <= nxt_data;
              pp_digit <= nxt_digit;
              pp_index <= nxt_idx;
              pp_last  <= nxt_last;
            end
          end
        end
        DONE: begin
          in_ready <= 1'b1;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_pp_sequencer.sv
// Self-checking bench for booth_pp_sequencer (WIDTH=8).
// The directed vectors come from a table of expected constants.
// A reset-abort sequence is written out by hand.
// Random pairs are checked against an arithmetic Booth model.
module tb_booth_pp_sequencer;

  localparam int W = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_a;
  logic [7:0]  in_b;
  logic        pp_valid;
  logic        pp_ready;
  logic [15:0] pp_data;
  logic [2:0]  pp_digit;
  logic [1:0]  pp_index;
  logic        pp_last;
  logic [15:0] prod;
  logic        prod_valid;

  int n_cmp = 0;
  int n_bad = 0;
  int tx_n  = 0;

  booth_pp_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b),
    .pp_valid(pp_valid), .pp_ready(pp_ready), .pp_data(pp_data),
    .pp_digit(pp_digit), .pp_index(pp_index), .pp_last(pp_last),
    .prod(prod), .prod_valid(prod_valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  a;
    logic [7:0]  b;
    logic [63:0] pps;   // pp i at [16*i +: 16]
    logic [11:0] dgs;   // digit i at [3*i +: 3]
    logic [15:0] prod;
    int          stall_idx;
    int          stall_n;
  } vec_t;

  vec_t tbl[4];

  function automatic void chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h required %0h (t=%0t)", nm, act, exp, $time);
    end
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic int bit_at(input logic [7:0] v, input int j);
    if (j < 0) return 0;
    return int'(v[j]);
  endfunction

  // Reference: digit_i = -2*b[2i+1] + b[2i] + b[2i-1]; pp_i = digit_i * a * 4^i.
  // The product is computed as a plain a*b.
  function automatic void model(input logic signed [7:0] a, input logic [7:0] b,
                                output logic [63:0] pps, output logic [11:0] dgs,
                                output logic [15:0] p_out);
    int d, p, full;
    pps = '0;
    dgs = '0;
    for (int i = 0; i < 4; i++) begin
      d = -2 * bit_at(b, 2*i+1) + bit_at(b, 2*i) + bit_at(b, 2*i-1);
      p = d * int'(a) * (1 << (2*i));
      pps[16*i +: 16] = p[15:0];
      case (d)
        1:       dgs[3*i +: 3] = 3'b001;
        2:       dgs[3*i +: 3] = 3'b010;
        -1:      dgs[3*i +: 3] = 3'b101;
        -2:      dgs[3*i +: 3] = 3'b110;
        default: dgs[3*i +: 3] = 3'b000;
      endcase
    end
    full  = int'(a) * int'($signed(b));
    p_out = full[15:0];
  endfunction

  // One complete operation, starting from IDLE. Every cycle is checked.
  // When rnd is set, pp_ready is random, and in_valid/in_a/in_b are randomized
  // while the block is busy. The block must not accept those inputs.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b,
                       input logic [63:0] pps, input logic [11:0] dgs,
                       input logic [15:0] eprod, input int stall_idx,
                       input int stall_n, input bit rnd);
    logic [15:0] sum;
    bit          r;
    bit          done_k;
    int          st;
    chk("in_ready_idle", 32'(in_ready), 32'd1);
    in_a     = a;
    in_b     = b;
    in_valid = 1'b1;
    if (rnd) pp_ready = 1'($urandom_range(0, 1));
    step();
    sum = '0;
    for (int k = 0; k < 4; k++) begin
      st     = 0;
      done_k = 1'b0;
      for (int c = 0; c < 200 && !done_k; c++) begin
        if (rnd) begin
          r        = 1'($urandom_range(0, 1));
          in_valid = 1'($urandom_range(0, 1));
          in_a     = 8'($urandom);
          in_b     = 8'($urandom);
        end else begin
          r        = !(k == stall_idx && st < stall_n);
          in_valid = 1'b0;
        end
        pp_ready = r;
        chk("pp_valid",   32'(pp_valid),   32'd1);
        chk("in_ready",   32'(in_ready),   32'd0);
        chk("prod_valid", 32'(prod_valid), 32'd0);
        chk("pp_index",   32'(pp_index),   32'(k));
        chk("pp_data",    32'(pp_data),    32'(pps[16*k +: 16]));
        chk("pp_digit",   32'(pp_digit),   32'(dgs[3*k +: 3]));
        chk("pp_last",    32'(pp_last),    32'(k == 3));
        if (r) sum = sum + pp_data;
        step();
        if (r) done_k = 1'b1;
        else   st++;
      end
      if (!done_k) begin
        n_cmp++;
        n_bad++;
        $display("FAIL pp_handshake_bound: index %0d not transferred in 200 cycles", k);
      end
    end
    chk("done_prod_valid", 32'(prod_valid), 32'd1);
    chk("done_prod",       32'(prod),       32'(eprod));
    chk("done_pp_sum",     32'(prod),       32'(sum));
    chk("done_pp_valid",   32'(pp_valid),   32'd0);
    chk("done_in_ready",   32'(in_ready),   32'd0);
    step();
    in_valid = 1'b0;
    chk("idle_prod_valid", 32'(prod_valid), 32'd0);
    chk("idle_in_ready",   32'(in_ready),   32'd1);
    chk("idle_prod_hold",  32'(prod),       32'(eprod));
    chk("idle_pp_valid",   32'(pp_valid),   32'd0);
    tx_n++;
    $display("tx %0d: a=%0d b=%0d prod=%h expected=%h", tx_n, $signed(a), $signed(b), prod, eprod);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_in_ready"},   32'(in_ready),   32'd1);
    chk({tag, "_pp_valid"},   32'(pp_valid),   32'd0);
    chk({tag, "_pp_data"},    32'(pp_data),    32'd0);
    chk({tag, "_pp_digit"},   32'(pp_digit),   32'd0);
    chk({tag, "_pp_index"},   32'(pp_index),   32'd0);
    chk({tag, "_pp_last"},    32'(pp_last),    32'd0);
    chk({tag, "_prod"},       32'(prod),       32'd0);
    chk({tag, "_prod_valid"}, 32'(prod_valid), 32'd0);
  endtask

  initial begin
    logic [63:0] m_pps;
    logic [11:0] m_dgs;
    logic [15:0] m_prod;
    logic [7:0]  ra, rb;

    tbl[0] = '{8'h03, 8'h05, {16'h0000, 16'h0000, 16'h000C, 16'h0003},
               {3'b000, 3'b000, 3'b001, 3'b001}, 16'h000F, -1, 0};
    tbl[1] = '{8'h80, 8'h80, {16'h4000, 16'h0000, 16'h0000, 16'h0000},
               {3'b110, 3'b000, 3'b000, 3'b000}, 16'h4000, -1, 0};
    tbl[2] = '{8'h7F, 8'hFF, {16'h0000, 16'h0000, 16'h0000, 16'hFF81},
               {3'b000, 3'b000, 3'b000, 3'b101}, 16'hFF81, -1, 0};
    tbl[3] = '{8'h03, 8'h05, {16'h0000, 16'h0000, 16'h000C, 16'h0003},
               {3'b000, 3'b000, 3'b001, 3'b001}, 16'h000F, 1, 3};

    rst      = 1'b1;
    in_valid = 1'b0;
    in_a     = '0;
    in_b     = '0;
    pp_ready = 1'b0;
    #1;
    chk_reset_outputs("reset");
    step();
    step();
    rst = 1'b0;
    chk_reset_outputs("post_reset");

    // Directed table: basic, extreme, negative digit, backpressure.
    for (int v = 0; v < 4; v++) begin
      pp_ready = 1'b1;
      do_op(tbl[v].a, tbl[v].b, tbl[v].pps, tbl[v].dgs, tbl[v].prod,
            tbl[v].stall_idx, tbl[v].stall_n, 1'b0);
    end

    // Reset abort while index 2 is presented (prod currently 0x000F).
    pp_ready = 1'b1;
    in_a     = 8'h03;
    in_b     = 8'h05;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
    step();
    step();
    chk("abort_at_index2", 32'(pp_index), 32'd2);
    rst = 1'b1;
    #1;
    chk_reset_outputs("abort");
    step();
    rst = 1'b0;
    for (int c = 0; c < 6; c++) begin
      chk("abort_no_prod_valid", 32'(prod_valid), 32'd0);
      chk("abort_prod_zero",     32'(prod),       32'd0);
      chk("abort_idle",          32'(in_ready),   32'd1);
      step();
    end
    do_op(8'hF9, 8'h06, {16'h0000, 16'h0000, 16'hFFC8, 16'h000E},
          {3'b000, 3'b000, 3'b010, 3'b110}, 16'hFFD6, -1, 0, 1'b0);

    // Random pairs, random backpressure, random in_valid noise while busy.
    for (int n = 0; n < 1000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      model(ra, rb, m_pps, m_dgs, m_prod);
      do_op(ra, rb, m_pps, m_dgs, m_prod, -1, 0, 1'b1);
      if ($urandom_range(0, 3) == 0) begin
        pp_ready = 1'($urandom_range(0, 1));
        step();
        chk("gap_idle_pp_valid", 32'(pp_valid), 32'd0);
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
